// File: rtl/beep_pkg.sv
// Shared types and defaults for the beep trigger front end.
// Cycle counts are derived from millisecond figures at the nominal system clock.
package beep_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } stretch_state_e;

    localparam int unsigned CLK_HZ           = 100_000_000;
    localparam int unsigned DEBOUNCE_MS      = 10;
    localparam int unsigned ALERT_STRETCH_MS = 20;

    function automatic int unsigned cycles_from_ms(input int unsigned ms,
                                                   input int unsigned clk_hz = CLK_HZ);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/beep_event_gen_if.sv
// Button/alarm inputs and beep trigger outputs of the event generator.
// The slave modport is the generator's view; master is the driving side.
interface beep_event_gen_if #(
    parameter int NUM_BTN = 4
);
    localparam int CODE_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

    logic [NUM_BTN-1:0] btn_raw;
    logic               alarm_in;
    logic               press_toggle;
    logic               alert_hold;
    logic               press_valid;
    logic [CODE_W-1:0]  press_code;

    modport master (
        output btn_raw,
        output alarm_in,
        input  press_toggle,
        input  alert_hold,
        input  press_valid,
        input  press_code
    );

    modport slave (
        input  btn_raw,
        input  alarm_in,
        output press_toggle,
        output alert_hold,
        output press_valid,
        output press_code
    );

endinterface

// File: rtl/button_debounce.sv
// One button: 2-flop synchronizer followed by a stability-counter debounce.
// Emits a single-cycle rise pulse on the same edge the debounced level goes 0->1.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronized input disagrees with the debounced level.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/beep_event_gen.sv
// Turns debounced button presses and the external alarm into the beep driver's
// toggle-per-press level and stretched alert pulse.
module beep_event_gen
    import beep_pkg::*;
#(
    parameter int          NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = cycles_from_ms(DEBOUNCE_MS),
    parameter int          ALERT_IDX       = 3,
    parameter int unsigned STRETCH_CYCLES  = cycles_from_ms(ALERT_STRETCH_MS)
) (
    input logic             clk,
    input logic             reset,
    beep_event_gen_if.slave bus
);

    localparam int CODE_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int SCW    = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam logic [SCW-1:0]     STRETCH_LAST = SCW'(STRETCH_CYCLES - 1);
    localparam logic [NUM_BTN-1:0] ALERT_MASK   = NUM_BTN'(1) << ALERT_IDX;

    logic [NUM_BTN-1:0] press_vec;
    logic               alert_event;

    logic               press_toggle_q, press_toggle_d;
    logic               press_valid_q, press_valid_d;
    logic [CODE_W-1:0]  press_code_q, press_code_d;
    logic               alarm_prev_q, alarm_prev_d;
    stretch_state_e     state_q, state_d;
    logic [SCW-1:0]     stretch_cnt_q, stretch_cnt_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(bus.btn_raw[i]),
            .rise   (press_vec[i])
        );
    end

    // The hold window is never restarted, so every alert gets a clean rising edge downstream.
    always_comb begin
        press_valid_d  = |press_vec;
        press_toggle_d = press_toggle_q ^ (|(press_vec & ~ALERT_MASK));
        press_code_d   = press_code_q;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press_vec[i]) begin
                press_code_d = CODE_W'(i);
            end
        end

        alarm_prev_d = bus.alarm_in;
        alert_event  = (|(press_vec & ALERT_MASK)) | (bus.alarm_in & ~alarm_prev_q);

        state_d       = state_q;
        stretch_cnt_d = stretch_cnt_q;
        case (state_q)
            IDLE: begin
                if (alert_event) begin
                    state_d       = HOLD;
                    stretch_cnt_d = '0;
                end
            end
            HOLD: begin
                if (stretch_cnt_q == STRETCH_LAST) begin
                    state_d       = IDLE;
                    stretch_cnt_d = '0;
                end else begin
                    stretch_cnt_d = stretch_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d       = IDLE;
                stretch_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_toggle_q <= 1'b0;
            press_valid_q  <= 1'b0;
            press_code_q   <= '0;
            alarm_prev_q   <= 1'b0;
            state_q        <= IDLE;
            stretch_cnt_q  <= '0;
        end else begin
            press_toggle_q <= press_toggle_d;
            press_valid_q  <= press_valid_d;
            press_code_q   <= press_code_d;
            alarm_prev_q   <= alarm_prev_d;
            state_q        <= state_d;
            stretch_cnt_q  <= stretch_cnt_d;
        end
    end

    assign bus.press_toggle = press_toggle_q;
    assign bus.press_valid  = press_valid_q;
    assign bus.press_code   = press_code_q;
    assign bus.alert_hold   = (state_q == HOLD);

endmodule

// File: tb/tb_beep_event_gen.sv
// Scoreboard bench for beep_event_gen: expected presses and hold windows are queued
// as stimulus is driven and matched against the outputs observed on falling edges.
module tb_beep_event_gen;

    localparam int NUM_BTN = 4;
    localparam int DEB     = 8;
    localparam int STR     = 16;
    localparam int ALERT   = 3;
    localparam int LAT     = 2 + DEB + 1;

    typedef struct {
        int cyc;
        int code;
        int toggle;
    } pressExp_t;

    typedef struct {
        int start;
        int len;
    } holdExp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    int   checkCount  = 0;
    int   passCount   = 0;
    int   modelToggle = 0;
    int   holdStart   = 0;
    bit   holdPrev    = 1'b0;
    bit   monEn       = 1'b0;

    pressExp_t pressQ[$];
    holdExp_t  holdQ[$];

    beep_event_gen_if #(.NUM_BTN(NUM_BTN)) dut_if ();

    beep_event_gen #(
        .NUM_BTN        (NUM_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .ALERT_IDX      (ALERT),
        .STRETCH_CYCLES (STR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (dut_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) passCount++;
        else $display("[TB] FAIL %s: observed %0d expected %0d at cycle %0d", tag, observed, expected, cyc);
    endtask

    task automatic monitorLoop();
        pressExp_t e;
        holdExp_t  h;
        forever begin
            @(negedge clk);
            if (!monEn || reset) begin
                holdPrev = 1'b0;
            end else begin
                if (dut_if.press_valid) begin
                    if (pressQ.size() == 0) begin
                        checkOutput("spurious_press_valid", int'(dut_if.press_valid), 0);
                    end else begin
                        e = pressQ.pop_front();
                        checkOutput("press_cycle", cyc, e.cyc);
                        checkOutput("press_code", int'(dut_if.press_code), e.code);
                        checkOutput("press_toggle", int'(dut_if.press_toggle), e.toggle);
                    end
                end
                if (dut_if.alert_hold && !holdPrev) holdStart = cyc;
                if (!dut_if.alert_hold && holdPrev) begin
                    if (holdQ.size() == 0) begin
                        checkOutput("spurious_hold_len", cyc - holdStart, 0);
                    end else begin
                        h = holdQ.pop_front();
                        checkOutput("hold_start", holdStart, h.start);
                        checkOutput("hold_len", cyc - holdStart, h.len);
                    end
                end
                holdPrev = dut_if.alert_hold;
            end
        end
    endtask

    // Raise the masked buttons for holdCycles, then release and idle.
    task automatic applyStimulus(input logic [NUM_BTN-1:0] mask, input int holdCycles,
                                 input int idleCycles);
        pressExp_t e;
        holdExp_t  h;
        if (mask != '0 && holdCycles >= DEB) begin
            e.cyc  = cyc + LAT;
            e.code = 0;
            for (int i = NUM_BTN - 1; i >= 0; i--) if (mask[i]) e.code = i;
            if ((mask & ~(NUM_BTN'(1) << ALERT)) != '0) modelToggle ^= 1;
            e.toggle = modelToggle;
            pressQ.push_back(e);
            if (mask[ALERT]) begin
                h.start = cyc + LAT;
                h.len   = STR;
                holdQ.push_back(h);
            end
        end
        dut_if.btn_raw = mask;
        repeat (holdCycles) @(posedge clk);
        #1 dut_if.btn_raw = '0;
        repeat (idleCycles) @(posedge clk);
        #1;
    endtask

    task automatic driveAlarm(input bit expectWindow, input int highCycles, input int lowCycles);
        holdExp_t h;
        if (expectWindow) begin
            h.start = cyc + 1;
            h.len   = STR;
            holdQ.push_back(h);
        end
        dut_if.alarm_in = 1'b1;
        repeat (highCycles) @(posedge clk);
        #1 dut_if.alarm_in = 1'b0;
        repeat (lowCycles) @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((pressQ.size() != 0 || holdQ.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain_press_q", pressQ.size(), 0);
        checkOutput("drain_hold_q", holdQ.size(), 0);
    endtask

    task automatic checkAllZero(input string phase);
        checkOutput({phase, "_press_toggle"}, int'(dut_if.press_toggle), 0);
        checkOutput({phase, "_alert_hold"}, int'(dut_if.alert_hold), 0);
        checkOutput({phase, "_press_valid"}, int'(dut_if.press_valid), 0);
        checkOutput({phase, "_press_code"}, int'(dut_if.press_code), 0);
    endtask

    initial begin
        dut_if.btn_raw  = '0;
        dut_if.alarm_in = 1'b0;
        fork
            monitorLoop();
        join_none

        repeat (3) @(posedge clk);
        #1 checkAllZero("in_reset");
        reset = 1'b0;
        repeat (50) @(posedge clk);
        #1 checkAllZero("idle");
        monEn = 1'b1;

        // Glitch shorter than the debounce window, then a real press of button 1.
        applyStimulus(4'b0010, 5, 15);
        applyStimulus(4'b0010, 20, 15);
        waitDrain(40);

        applyStimulus(4'b0001, 12, 14);
        applyStimulus(4'b0100, 12, 14);
        waitDrain(40);
        checkOutput("press_code_held", int'(dut_if.press_code), 2);

        applyStimulus(4'b1000, 12, 14);
        waitDrain(40);

        // Alarm retrigger inside the hold window must not extend it.
        driveAlarm(1'b1, 3, 5);
        driveAlarm(1'b0, 2, 20);
        driveAlarm(1'b1, 3, 20);
        waitDrain(40);

        applyStimulus(4'b1001, 12, 14);
        waitDrain(40);
        checkOutput("press_code_held_simul", int'(dut_if.press_code), 0);

        // Reset during a hold window with a partially debounced button 1.
        monEn = 1'b0;
        dut_if.alarm_in = 1'b1;
        dut_if.btn_raw  = 4'b0010;
        repeat (6) @(posedge clk);
        #1 checkOutput("hold_before_reset", int'(dut_if.alert_hold), 1);
        #2 reset = 1'b1;
        #1 checkAllZero("reset_abort");
        dut_if.alarm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        modelToggle = 0;
        monEn = 1'b1;
        repeat (4) @(posedge clk);
        #1 dut_if.btn_raw = '0;
        repeat (30) @(posedge clk);
        #1;
        applyStimulus(4'b0010, 12, 14);
        waitDrain(40);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
